// File: rtl/step_sequencer.sv
// step_sequencer: instruction-cycle timing generator for the control path.
// Walks the micro-step index T0..T(LAST_STEP) on `add` (feeds the one-hot
// step decoder) with run / halt / single-step control, memory-wait stalls,
// early instruction termination and a retired-instruction counter.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        begin or resume execution (ignored in RUN / STEP_WAIT)
//   halt_req     halt at the next instruction boundary (latched)
//   stall        freeze the step index this cycle
//   seq_clr      current step is the last one of this instruction
//   single       pause in STEP_WAIT after each instruction
//   step_go      leave the single-step pause
//   add          current step index
//   running      registered (state == RUN)
//   halted       registered (state == HALTED)
//   instr_done   one-cycle pulse when an instruction retires
//   icount       retired-instruction count, wraps modulo 2^ICNT_W
module step_sequencer #(
    parameter int unsigned LAST_STEP = 8,
    parameter int unsigned ICNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              stall,
    input  logic              seq_clr,
    input  logic              single,
    input  logic              step_go,
    output logic [3:0]        add,
    output logic              running,
    output logic              halted,
    output logic              instr_done,
    output logic [ICNT_W-1:0] icount
);

    localparam int unsigned ADD_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t state;
    logic   halt_pend;
    logic   boundary_c;
    logic   halt_now_c;

    // An unstalled RUN cycle on the last step (or early end) retires the instruction.
    assign boundary_c = (state == RUN) && !stall &&
                        ((add == ADD_W'(LAST_STEP)) || seq_clr);

    // A halt request in the boundary cycle itself is honoured without waiting.
    assign halt_now_c = halt_pend || halt_req;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            add        <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
            instr_done <= 1'b0;
            icount     <= '0;
            halt_pend  <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            if (halt_req) begin
                halt_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    add <= '0;
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end

                RUN: begin
                    if (boundary_c) begin
                        add        <= '0;
                        instr_done <= 1'b1;
                        icount     <= icount + ICNT_W'(1);
                        if (halt_now_c) begin
                            state     <= HALTED;
                            running   <= 1'b0;
                            halted    <= 1'b1;
                            halt_pend <= 1'b0;
                        end else if (single) begin
                            state   <= STEP_WAIT;
                            running <= 1'b0;
                        end
                    end else if (!stall) begin
                        add <= add + ADD_W'(1);
                    end
                end

                STEP_WAIT: begin
                    add <= '0;
                    if (halt_now_c) begin
                        state     <= HALTED;
                        halted    <= 1'b1;
                        halt_pend <= 1'b0;
                    end else if (step_go) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end

                HALTED: begin
                    add <= '0;
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        halted  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    add     <= '0;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
